// File: rtl/dram_word_ctrl.sv
// dram_word_ctrl: word-wide, byte-enabled, little-endian simulation DRAM with an
// open-row latency model. One request is in flight at a time.
//   clk, rst           clock, synchronous active-high reset
//   req_valid/ready    request handshake (ready only while idle)
//   req_we, req_addr   write flag, byte address (must be word aligned)
//   req_wdata, req_be  write data and per-byte-lane write enables
//   resp_valid         one-cycle response pulse
//   resp_rdata         read data (0 for writes and errors), held until next response
//   resp_err           misaligned request flag, held until next response
module dram_word_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 16384,
  parameter int COL_BITS    = 8,
  parameter int HIT_LAT     = 1,
  parameter int MISS_LAT    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int ROW_W = IDX_W - COL_BITS;
  localparam int CNT_W = $clog2(MISS_LAT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  row_open_q, row_open_d;
  logic [ROW_W-1:0]      open_row_q, open_row_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  // captured request
  logic                  we_q, we_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BYTES-1:0]      be_q, be_d;
  logic                  err_q, err_d;

  logic                  mem_we;
  logic [IDX_W-1:0]      req_idx;
  logic [ROW_W-1:0]      req_row;
  logic                  req_mis;
  logic                  unused_addr;

  // word index wraps modulo depth: upper address bits simply alias
  assign req_idx     = req_addr[OFF_W +: IDX_W];
  assign req_row     = req_idx[IDX_W-1 -: ROW_W];
  assign req_mis     = |req_addr[OFF_W-1:0];
  assign unused_addr = ^req_addr[ADDR_WIDTH-1:OFF_W+IDX_W];

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_open_d   = row_open_q;
    open_row_d   = open_row_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    we_d         = we_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    err_d        = err_q;
    mem_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          idx_d   = req_idx;
          wdata_d = req_wdata;
          be_d    = req_be;
          err_d   = req_mis;
          state_d = S_WAIT;
          if (req_mis) begin
            // error path: fixed 1-cycle latency, row state untouched
            cnt_d = '0;
          end else if (!row_open_q || (req_row != open_row_q)) begin
            cnt_d      = CNT_W'(MISS_LAT - 1);
            open_row_d = req_row;
            row_open_d = 1'b1;
          end else begin
            cnt_d = CNT_W'(HIT_LAT - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          // access happens on the edge that raises resp_valid
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = err_q;
          resp_rdata_d = (err_q || we_q) ? '0 : mem[idx_q];
          mem_we       = we_q && !err_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      row_open_q   <= 1'b0;
      open_row_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_open_q   <= row_open_d;
      open_row_q   <= open_row_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // request capture needs no reset: only consumed after a fresh accept
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
    err_q   <= err_d;
  end

  // storage is never reset; an in-flight write is dropped when rst is high
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int k = 0; k < BYTES; k++) begin
        if (be_q[k]) mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dram_word_ctrl.sv
module tb_dram_word_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_total = 0;
  int n_pass  = 0;

  dram_word_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // reference model: word store, open-row tracking, latency from the rules
  logic [31:0] m_mem [int];
  bit          m_open = 1'b0;
  int          m_row  = 0;

  function automatic void model_req(input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] be,
                                    output int lat, output logic [31:0] rd, output logic er);
    int idx, row;
    logic [31:0] w;
    idx = (addr / 4) % 16384;
    row = idx / 256;
    rd = '0; er = 1'b0;
    if (addr % 4 != 0) begin
      lat = 1; er = 1'b1;
    end else begin
      if (!m_open || row != m_row) begin
        lat = 4; m_row = row; m_open = 1'b1;
      end else lat = 1;
      w = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
      if (we) begin
        for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = wdata[8*k +: 8];
        m_mem[idx] = w;
      end else rd = w;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_open = 1'b0;
  endtask

  // issue one request; measure accept->response latency; optionally wiggle req_*
  // while busy (must have no effect)
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit garbage,
                        output int lat, output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    lat = -1; rd = 'x; er = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      if (garbage) begin
        req_valid = 1'($urandom); req_we = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
      end else req_valid = 1'b0;
      @(posedge clk); #1;
      if (resp_valid) begin lat = c; break; end
    end
    req_valid = 1'b0;
    if (lat < 0) begin
      chk("resp_timeout", 32'd0, 32'd1);
    end else begin
      rd = resp_rdata; er = resp_err;
      chk("ready_low_in_resp", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      chk("resp_pulse_width", 32'(resp_valid), 32'd0);
      chk("ready_after_resp", 32'(req_ready), 32'd1);
    end
  endtask

  typedef struct {
    bit          do_rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat, mlat;
    logic [31:0] rd, mrd;
    logic er, mer;
    int seen;

    vecs.push_back('{1, 0, 32'h100,   32'h0,        4'hF, 4, 32'h0,        0});
    vecs.push_back('{1, 1, 32'h100,   32'hDEADBEEF, 4'hF, 4, 32'h0,        0});
    vecs.push_back('{0, 0, 32'h100,   32'h0,        4'hF, 1, 32'hDEADBEEF, 0});
    vecs.push_back('{0, 1, 32'h100,   32'h11223344, 4'h5, 1, 32'h0,        0});
    vecs.push_back('{0, 0, 32'h100,   32'h0,        4'h0, 1, 32'hDE22BE44, 0});
    vecs.push_back('{0, 0, 32'h102,   32'h0,        4'hF, 1, 32'h0,        1});
    vecs.push_back('{0, 0, 32'h100,   32'h0,        4'hF, 1, 32'hDE22BE44, 0});
    vecs.push_back('{0, 0, 32'h400,   32'h0,        4'hF, 4, 32'h0,        0});
    vecs.push_back('{0, 0, 32'h100,   32'h0,        4'hF, 4, 32'hDE22BE44, 0});
    vecs.push_back('{0, 0, 32'h10100, 32'h0,        4'hF, 1, 32'hDE22BE44, 0});
    vecs.push_back('{0, 1, 32'h100,   32'hFFFFFFFF, 4'h0, 1, 32'h0,        0});
    vecs.push_back('{0, 0, 32'h100,   32'h0,        4'hF, 1, 32'hDE22BE44, 0});
    vecs.push_back('{0, 1, 32'h103,   32'hFFFFFFFF, 4'hF, 1, 32'h0,        1});
    vecs.push_back('{0, 0, 32'h100,   32'h0,        4'hF, 1, 32'hDE22BE44, 0});
    vecs.push_back('{0, 1, 32'hFFFC,  32'hA5A5C3C3, 4'hF, 4, 32'h0,        0});
    vecs.push_back('{0, 0, 32'hFFFC,  32'h0,        4'hF, 1, 32'hA5A5C3C3, 0});

    // reset state
    do_reset();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b0, lat, rd, er);
      model_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, mlat, mrd, mer);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].err));
    end

    // reset two cycles into a miss write: dropped, and req_valid ignored during reset
    do_reset();
    while (!req_ready) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h200; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; m_open = 1'b0;
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    chk("rst_mid_no_resp", 32'(seen), 32'd0);
    do_req(1'b0, 32'h200, 32'h0, 4'hF, 1'b0, lat, rd, er);
    model_req(1'b0, 32'h200, 32'h0, 4'hF, mlat, mrd, mer);
    chk("rst_mid_read_lat", 32'(lat), 32'd4);
    chk("rst_mid_read_data", rd, 32'h0);

    // randomized traffic against the reference model, with busy-time input noise
    for (int t = 0; t < 300; t++) begin
      logic        we;
      logic [31:0] addr, wdata;
      logic [3:0]  be;
      int          rows[4];
      rows = '{0, 1, 2, 63};
      we    = 1'($urandom);
      addr  = ($urandom & 32'hFFFF_0000) | (32'(rows[$urandom_range(0, 3)]) << 10) |
              (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
      wdata = $urandom;
      be    = 4'($urandom);
      do_req(we, addr, wdata, be, 1'($urandom), lat, rd, er);
      model_req(we, addr, wdata, be, mlat, mrd, mer);
      chk($sformatf("rnd%0d_lat", t), 32'(lat), 32'(mlat));
      chk($sformatf("rnd%0d_rdata", t), rd, mrd);
      chk($sformatf("rnd%0d_err", t), 32'(er), 32'(mer));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
